// File: rtl/cache_mgmt_unit.sv
// rtl/cache_mgmt_unit.sv - 2-way set-associative cache controller: hit service, victim write-back, line refill
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   en_r, en_w                CPU read / write request (write wins when both set)
//   addr_rw, u_b_h_w, data_w  CPU byte address, RV32I width code, store data
//   data_r, stall             CPU load data, CPU hold request
//   cache_addr, cache_load, cache_store, cache_replace, cache_invalid,
//   cache_u_b_h_w, cache_din  cache array command port
//   cache_hit, cache_valid, cache_dirty, cache_tag, cache_dout
//                             cache array status/data for cache_addr
//   mem_cs_o, mem_we_o, mem_addr_o, mem_data_o, mem_data_i, mem_ack_i
//                             word-wide memory port, one word per ack

module cache_mgmt_unit #(
    parameter int ADDR_BITS        = 32,
    parameter int TAG_BITS         = 23,
    parameter int SET_INDEX_WIDTH  = 5,
    parameter int LINE_WORDS       = 4,
    parameter int LINE_WORDS_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_r,
    input  logic                   en_w,
    input  logic [ADDR_BITS-1:0]   addr_rw,
    input  logic [2:0]             u_b_h_w,
    input  logic [31:0]            data_w,
    output logic [31:0]            data_r,
    output logic                   stall,
    output logic [ADDR_BITS-1:0]   cache_addr,
    output logic                   cache_load,
    output logic                   cache_store,
    output logic                   cache_replace,
    output logic                   cache_invalid,
    output logic [2:0]             cache_u_b_h_w,
    output logic [31:0]            cache_din,
    input  logic                   cache_hit,
    input  logic                   cache_valid,
    input  logic                   cache_dirty,
    input  logic [TAG_BITS-1:0]    cache_tag,
    input  logic [31:0]            cache_dout,
    output logic                   mem_cs_o,
    output logic                   mem_we_o,
    output logic [ADDR_BITS-1:0]   mem_addr_o,
    output logic [31:0]            mem_data_o,
    input  logic [31:0]            mem_data_i,
    input  logic                   mem_ack_i
);

    localparam int OFFSET_LSB = LINE_WORDS_WIDTH + 2;

    typedef enum logic [1:0] {S_IDLE, S_BACK, S_FILL, S_WAIT} state_t;

    state_t                       state;
    logic [LINE_WORDS_WIDTH-1:0]  word_cnt;
    logic [TAG_BITS-1:0]          req_tag;
    logic [SET_INDEX_WIDTH-1:0]   req_index;
    logic [TAG_BITS-1:0]          victim_tag;

    logic                         req;
    logic                         last_word;
    logic [ADDR_BITS-1:0]         fill_addr;
    logic [ADDR_BITS-1:0]         back_addr;

    assign req       = en_r | en_w;
    assign last_word = (word_cnt == LINE_WORDS_WIDTH'(LINE_WORDS - 1));
    assign fill_addr = {req_tag, req_index, word_cnt, 2'b00};
    assign back_addr = {victim_tag, req_index, word_cnt, 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            word_cnt   <= '0;
            req_tag    <= '0;
            req_index  <= '0;
            victim_tag <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req && !cache_hit) begin
                        req_tag    <= addr_rw[ADDR_BITS-1 -: TAG_BITS];
                        req_index  <= addr_rw[OFFSET_LSB +: SET_INDEX_WIDTH];
                        victim_tag <= cache_tag;
                        word_cnt   <= '0;
                        state      <= (cache_valid && cache_dirty) ? S_BACK : S_FILL;
                    end
                end
                S_BACK: begin
                    // word_cnt wraps to 0 on the last ack, ready for the refill
                    if (mem_ack_i) begin
                        word_cnt <= word_cnt + LINE_WORDS_WIDTH'(1);
                        if (last_word) state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (mem_ack_i) begin
                        word_cnt <= word_cnt + LINE_WORDS_WIDTH'(1);
                        if (last_word) state <= S_WAIT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        data_r        = '0;
        stall         = 1'b0;
        cache_addr    = addr_rw;
        cache_load    = 1'b0;
        cache_store   = 1'b0;
        cache_replace = 1'b0;
        cache_invalid = 1'b0;
        cache_u_b_h_w = u_b_h_w;
        cache_din     = data_w;
        mem_cs_o      = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = '0;
        mem_data_o    = '0;
        case (state)
            S_IDLE, S_WAIT: begin
                // S_WAIT replays the original request against the freshly filled line
                if (state == S_WAIT || (req && cache_hit)) begin
                    cache_store = en_w;
                    cache_load  = en_r & ~en_w;
                    data_r      = cache_dout;
                end else if (req) begin
                    stall = 1'b1;
                end
            end
            S_BACK: begin
                // cache_addr misses, so the array presents the victim word
                stall         = 1'b1;
                cache_addr    = fill_addr;
                cache_u_b_h_w = 3'b010;
                mem_cs_o      = 1'b1;
                mem_we_o      = 1'b1;
                mem_addr_o    = back_addr;
                mem_data_o    = cache_dout;
            end
            default: begin
                stall         = 1'b1;
                cache_addr    = fill_addr;
                cache_u_b_h_w = 3'b010;
                mem_cs_o      = 1'b1;
                mem_addr_o    = fill_addr;
                if (mem_ack_i) begin
                    cache_replace = 1'b1;
                    cache_din     = mem_data_i;
                end
            end
        endcase
        // strobes and handshakes must fall with reset, not a clock edge later
        if (!rst) begin
            stall         = 1'b0;
            cache_load    = 1'b0;
            cache_store   = 1'b0;
            cache_replace = 1'b0;
            mem_cs_o      = 1'b0;
        end
    end

endmodule

// File: tb/tb_cache_mgmt_unit.sv
// tb/tb_cache_mgmt_unit.sv - directed and randomized bench for cache_mgmt_unit with cache array and memory models

module tb_cache_mgmt_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_r, en_w;
    logic [31:0] addr_rw;
    logic [2:0]  u_b_h_w;
    logic [31:0] data_w;
    logic [31:0] data_r;
    logic        stall;
    logic [31:0] cache_addr;
    logic        cache_load, cache_store, cache_replace, cache_invalid;
    logic [2:0]  cache_u_b_h_w;
    logic [31:0] cache_din;
    logic        cache_hit, cache_valid, cache_dirty;
    logic [22:0] cache_tag;
    logic [31:0] cache_dout;
    logic        mem_cs_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_data_o;
    logic [31:0] mem_data_i;
    logic        mem_ack_i;

    always #5 clk = ~clk;

    cache_mgmt_unit dut (
        .clk(clk), .rst(rst), .en_r(en_r), .en_w(en_w), .addr_rw(addr_rw),
        .u_b_h_w(u_b_h_w), .data_w(data_w), .data_r(data_r), .stall(stall),
        .cache_addr(cache_addr), .cache_load(cache_load), .cache_store(cache_store),
        .cache_replace(cache_replace), .cache_invalid(cache_invalid),
        .cache_u_b_h_w(cache_u_b_h_w), .cache_din(cache_din), .cache_hit(cache_hit),
        .cache_valid(cache_valid), .cache_dirty(cache_dirty), .cache_tag(cache_tag),
        .cache_dout(cache_dout), .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
        .mem_ack_i(mem_ack_i)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        case (a)
            32'h100: return 32'h11;
            32'h104: return 32'h22;
            32'h108: return 32'h33;
            32'h10C: return 32'h44;
            default: return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] a,
                                          input logic [2:0] w, input logic [31:0] d);
        logic [31:0] r;
        r = old;
        case (w[1:0])
            2'b00:   r[a[1:0]*8 +: 8]  = d[7:0];
            2'b01:   r[a[1]*16 +: 16]  = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    // ---------------- memory model ----------------
    typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } mem_op_t;
    mem_op_t     mem_log[$];
    logic [31:0] mem_arr [logic [31:0]];
    int          ack_delay = 0;
    int          wait_cnt = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : init_word(a);
    endfunction

    initial begin
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
    end

    always @(negedge clk) begin
        mem_op_t op;
        if (!rst) begin
            mem_ack_i = 1'b0;
            wait_cnt  = 0;
        end else if (mem_ack_i) begin
            mem_ack_i = 1'b0;
        end else if (mem_cs_o) begin
            if (wait_cnt >= ack_delay) begin
                wait_cnt  = 0;
                op.we     = mem_we_o;
                op.addr   = mem_addr_o;
                op.data   = mem_we_o ? mem_data_o : mem_rd(mem_addr_o);
                mem_log.push_back(op);
                if (mem_we_o) mem_arr[mem_addr_o] = mem_data_o;
                else          mem_data_i = op.data;
                mem_ack_i = 1'b1;
            end else begin
                wait_cnt++;
            end
        end
    end

    // ---------------- cache array model (2-way, LRU) ----------------
    logic [1:0]  valid_a [32];
    logic [1:0]  dirty_a [32];
    logic        lru_a   [32];
    logic [22:0] tag_a   [32][2];
    logic [31:0] data_a  [32][2][4];
    logic [31:0] inv_mask = '0;
    logic [4:0]  c_idx;
    logic [1:0]  c_word;
    logic [22:0] c_tag;
    logic        c_way, h0, h1;

    always_comb begin
        c_idx       = cache_addr[8:4];
        c_word      = cache_addr[3:2];
        c_tag       = cache_addr[31:9];
        h0          = valid_a[c_idx][0] && (tag_a[c_idx][0] == c_tag);
        h1          = valid_a[c_idx][1] && (tag_a[c_idx][1] == c_tag);
        cache_hit   = h0 | h1;
        c_way       = h0 ? 1'b0 : (h1 ? 1'b1 : lru_a[c_idx]);
        cache_valid = valid_a[c_idx][c_way];
        cache_dirty = dirty_a[c_idx][c_way];
        cache_tag   = tag_a[c_idx][c_way];
        cache_dout  = data_a[c_idx][c_way][c_word];
    end

    always @(posedge clk) begin
        for (int s = 0; s < 32; s++) begin
            if (inv_mask[s]) begin
                valid_a[s] <= 2'b00;
                dirty_a[s] <= 2'b00;
                lru_a[s]   <= 1'b0;
            end
        end
        if (cache_store && cache_hit) begin
            data_a[c_idx][c_way][c_word] <= merge(cache_dout, cache_addr, cache_u_b_h_w, cache_din);
            dirty_a[c_idx][c_way]        <= 1'b1;
            lru_a[c_idx]                 <= ~c_way;
        end else if (cache_load && cache_hit) begin
            lru_a[c_idx] <= ~c_way;
        end
        if (cache_replace) begin
            data_a[c_idx][c_way][c_word] <= cache_din;
            if (!cache_hit) begin
                tag_a[c_idx][c_way]   <= c_tag;
                valid_a[c_idx][c_way] <= 1'b1;
                dirty_a[c_idx][c_way] <= 1'b0;
            end
            lru_a[c_idx] <= ~c_way;
        end
    end

    // ---------------- reference: a flat, always-coherent memory ----------------
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
    endfunction

    // ---------------- CPU access helpers ----------------
    logic obs_load, obs_store;

    task automatic finish_access(output logic [31:0] rdata, output int cyc);
        logic timed_out;
        timed_out = 1'b1;
        cyc = 0;
        for (int n = 0; n < 400; n++) begin
            #1;
            if (!stall) begin
                timed_out = 1'b0;
                break;
            end
            cyc++;
            @(negedge clk);
        end
        check("access_complete", {31'b0, timed_out}, 32'd0);
        rdata     = data_r;
        obs_load  = cache_load;
        obs_store = cache_store;
        @(posedge clk);
        #1;
        en_r = 1'b0;
        en_w = 1'b0;
    endtask

    task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                          input logic [2:0] w, input logic [31:0] d,
                          output logic [31:0] rdata, output int cyc);
        @(negedge clk);
        en_w = wr; en_r = rd; addr_rw = a; u_b_h_w = w; data_w = d;
        finish_access(rdata, cyc);
        if (wr) ref_mem[{a[31:2], 2'b00}] = merge(ref_rd(a), a, w, d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd_v;
        logic [31:0] a;
        logic [2:0]  w;
        int          cyc;
        int          base;
        int          op;
        logic [31:0] exp_wb [4];

        rst = 1'b0; en_r = 1'b0; en_w = 1'b0;
        addr_rw = '0; u_b_h_w = 3'b010; data_w = '0;
        inv_mask = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        inv_mask = '0;
        #1;
        check("reset stall", {31'b0, stall}, 0);
        check("reset mem_cs", {31'b0, mem_cs_o}, 0);
        check("reset strobes", {28'b0, cache_load, cache_store, cache_replace, cache_invalid}, 0);
        rst = 1'b1;

        // 1: cold LW 0x104
        base = mem_log.size();
        access(1'b0, 1'b1, 32'h104, 3'b010, '0, rd_v, cyc);
        check("t1 log size", mem_log.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1 rd%0d we", i), {31'b0, mem_log[base+i].we}, 0);
            check($sformatf("t1 rd%0d addr", i), mem_log[base+i].addr, 32'h100 + 32'(4*i));
            check($sformatf("t1 rd%0d data", i), mem_log[base+i].data, 32'h11 * 32'(i+1));
        end
        check("t1 data_r", rd_v, 32'h22);

        // 2: hit, no stall, no memory traffic
        base = mem_log.size();
        access(1'b0, 1'b1, 32'h104, 3'b010, '0, rd_v, cyc);
        check("t2 stall cycles", cyc, 0);
        check("t2 data_r", rd_v, 32'h22);
        check("t2 mem traffic", mem_log.size() - base, 0);

        // 3a: SB hit marks the line dirty
        access(1'b1, 1'b0, 32'h105, 3'b000, 32'hAB, rd_v, cyc);
        check("t3 sb stall cycles", cyc, 0);
        // 6: read+write on a hit is a store only
        access(1'b1, 1'b1, 32'h10C, 3'b010, 32'h44, rd_v, cyc);
        check("t6 stall cycles", cyc, 0);
        check("t6 store strobe", {31'b0, obs_store}, 1);
        check("t6 load strobe", {31'b0, obs_load}, 0);
        // 3b: fill other way, no write-back
        base = mem_log.size();
        access(1'b0, 1'b1, 32'h2104, 3'b010, '0, rd_v, cyc);
        check("t3 fill2 log", mem_log.size() - base, 4);
        check("t3 fill2 data", rd_v, ref_rd(32'h2104));
        // 3c: evict dirty line 0x100
        exp_wb[0] = 32'h11; exp_wb[1] = 32'h0000AB22; exp_wb[2] = 32'h33; exp_wb[3] = 32'h44;
        base = mem_log.size();
        access(1'b0, 1'b1, 32'h4104, 3'b010, '0, rd_v, cyc);
        check("t3 evict log", mem_log.size() - base, 8);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3 wb%0d we", i), {31'b0, mem_log[base+i].we}, 1);
            check($sformatf("t3 wb%0d addr", i), mem_log[base+i].addr, 32'h100 + 32'(4*i));
            check($sformatf("t3 wb%0d data", i), mem_log[base+i].data, exp_wb[i]);
            check($sformatf("t3 fl%0d we", i), {31'b0, mem_log[base+4+i].we}, 0);
            check($sformatf("t3 fl%0d addr", i), mem_log[base+4+i].addr, 32'h4100 + 32'(4*i));
        end
        check("t3 data_r", rd_v, ref_rd(32'h4104));

        // 4: withheld ack keeps the request frozen
        ack_delay = 5;
        @(negedge clk);
        en_r = 1'b1; en_w = 1'b0; addr_rw = 32'h6104; u_b_h_w = 3'b010;
        #1;
        check("t4 miss stall", {31'b0, stall}, 1);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("t4 hold%0d cs", i), {31'b0, mem_cs_o}, 1);
            check($sformatf("t4 hold%0d addr", i), mem_addr_o, 32'h6100);
            check($sformatf("t4 hold%0d stall", i), {31'b0, stall}, 1);
            check($sformatf("t4 hold%0d noack", i), {31'b0, mem_ack_i}, 0);
            @(negedge clk);
        end
        finish_access(rd_v, cyc);
        check("t4 data_r", rd_v, ref_rd(32'h6104));

        // 5: reset in the middle of a refill
        ack_delay = 2;
        base = mem_log.size();
        @(negedge clk);
        en_r = 1'b1; addr_rw = 32'h8104;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            #1;
            if (mem_log.size() - base >= 2) break;
        end
        check("t5 two acks", mem_log.size() - base, 2);
        check("t5 pre replace", {31'b0, cache_replace}, 1);
        check("t5 pre stall", {31'b0, stall}, 1);
        rst = 1'b0;
        en_r = 1'b0;
        #1;
        check("t5 stall", {31'b0, stall}, 0);
        check("t5 mem_cs", {31'b0, mem_cs_o}, 0);
        check("t5 replace", {31'b0, cache_replace}, 0);
        @(negedge clk);
        inv_mask[16] = 1'b1;
        @(negedge clk);
        inv_mask = '0;
        rst = 1'b1;
        access(1'b0, 1'b1, 32'h104, 3'b010, '0, rd_v, cyc);
        check("t5 after reset data", rd_v, ref_rd(32'h104));

        // randomized loads/stores over two sets and four tags
        for (int k = 0; k < 80; k++) begin
            ack_delay = $urandom_range(0, 2);
            op = $urandom_range(0, 2);
            a  = {21'($urandom_range(0, 3)), 2'b00, 5'($urandom_range(3, 4)),
                  2'($urandom_range(0, 3)), 2'b00};
            if (op == 2) begin
                a[1:0] = 2'($urandom_range(0, 3));
                w = 3'b000;
            end else begin
                w = 3'b010;
            end
            if (op == 0) begin
                access(1'b0, 1'b1, a, w, '0, rd_v, cyc);
                check($sformatf("rnd%0d lw %h", k, a), rd_v, ref_rd(a));
            end else begin
                access(1'b1, 1'b0, a, w, $urandom, rd_v, cyc);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
